// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, with signs fixed up at the end.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] result_q;

    logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_n, lo_n, quo, rem, final_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign in_ready  = (state_q == StIdle) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;

    // Decode operand signedness and the special-case divides at accept.
    always_comb begin
        is_div   = op[2];
        // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed.
        a_sgn    = is_div ? !op[0] : (op != 3'b011);
        b_sgn    = is_div ? !op[0] : !op[1];
        a_neg    = a_sgn && op_a[XLEN-1];
        b_neg    = b_sgn && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = !op[0] && (op_a == MinInt) && (op_b == '1);
        fast     = is_div && (div_zero || div_ovf);
        if (div_zero) begin
            fast_res = op[1] ? op_a : '1;
        end else begin
            fast_res = op[1] ? '0 : op_a;
        end
    end

    // One iteration step plus the sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_shift[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo      = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
        rem      = a_neg_q ? -hi_n : hi_n;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; flush overrides both accept and handoff.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = fast ? StDone : StCalc;
            StCalc:  if (cnt_q == CntLast) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load magnitudes on accept, iterate in CALC, latch the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q    <= op;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                hi_q    <= '0;
                lo_q    <= a_mag;
                b_q     <= b_mag;
                cnt_q   <= '0;
                if (fast) result_q <= fast_res;
            end else if (state_q == StCalc) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CntLast) result_q <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [31:0] MinInt = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;
    bit rand_ready = 1'b0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (o)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinInt && b == 32'hFFFF_FFFF) return MinInt;
                return qa / qb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinInt && b == 32'hFFFF_FFFF) return 32'd0;
                return qa % qb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == MinInt && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Monitor: every handoff pops one expected result.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%08h expected none", result);
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic accept_only(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        in_valid = 1'b1;
        op = o;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat = 1;
        exp_q.push_back(model(o, a, b));
        accept_only(o, a, b);
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(model_lat(o, a, b)));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = MinInt;
            3: v = 32'd1;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int seen;
        logic [31:0] e;
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        flush = 1'b1;
        #1;
        chk("in_ready_flush", 32'(in_ready), 32'd0);
        flush = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases
        launch(3'd0, 32'd7, 32'hFFFF_FFFD);          drain();
        launch(3'd1, MinInt, MinInt);                drain();
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  drain();
        launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  drain();
        launch(3'd4, 32'hFFFF_FFF9, 32'd2);          drain();
        launch(3'd6, 32'hFFFF_FFF9, 32'd2);          drain();
        launch(3'd5, 32'd5, 32'd0);                  drain();
        launch(3'd7, 32'd5, 32'd0);                  drain();
        launch(3'd4, MinInt, 32'hFFFF_FFFF);         drain();
        launch(3'd6, MinInt, 32'hFFFF_FFFF);         drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        e = model(3'd4, 32'hFFFF_FFF9, 32'd2);
        launch(3'd4, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, e);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", 32'(busy), 32'd0);
        drain();

        // Flush during CALC
        accept_only(3'd0, 32'd100, 32'd200);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        launch(3'd0, 32'd3, 32'd4);
        drain();

        // Reset during CALC
        accept_only(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        launch(3'd0, 32'd3, 32'd4);
        drain();

        // Random operations with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            launch(3'($urandom), pick(), pick());
            drain();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN: default 32; operand and result width; legal values are even and >= 8.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 op  input  3  RV32M funct3 encoding:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-007 op_a  input  XLEN  rs1 operand.
REQ-008 op_b  input  XLEN  rs2 operand.
REQ-009 flush  input  1  abandon any in-flight operation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  XLEN  operation result.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The unit SHALL implement the states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only when the state is IDLE and flush is 0.
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1 at a clock edge.
- On accept, the unit latches op, op_a, op_b and the operand signs.
- Inputs SHALL be ignored in all other cycles.
REQ-017 Normal path: accept → CALC for exactly XLEN cycles, one iteration per cycle, under a log2(XLEN)-bit counter → DONE.
- With accept in cycle 0, out_valid SHALL first be high in cycle XLEN+1.
REQ-018 Fast path: divide ops with op_b==0, and DIV/REM with op_a==MIN_INT and op_b==all-ones, SHALL go from accept directly to DONE.
- out_valid SHALL be high in cycle 1.
REQ-019 Multiply SHALL use shift-add on magnitudes into a 2*XLEN product, negated at the end when the effective signs differ.
- MUL returns the low XLEN bits.
- MULH returns the high XLEN bits, signed×signed.
- MULHSU returns the high XLEN bits, signed×unsigned.
- MULHU returns the high XLEN bits, unsigned×unsigned.
REQ-020 Divide SHALL use restoring division on magnitudes.
- Signed quotient is negated when the operand signs differ.
- Signed remainder takes the sign of the dividend.
REQ-021 Divide by zero: quotient SHALL be all-ones; remainder SHALL equal op_a.
REQ-022 Signed overflow (MIN_INT / -1): DIV SHALL return MIN_INT; REM SHALL return 0.
REQ-023 In DONE, out_valid SHALL be 1 and result SHALL stay stable until out_ready is 1.
- The next state is then IDLE.
- There is no accept in the same cycle as the handoff; the minimum gap between results is one IDLE cycle.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge and discard the result.
- out_valid SHALL be 0 from that edge onward.
- flush has priority over both accept and handoff.
REQ-025 result SHALL hold its last value outside DONE and SHALL NOT be read when out_valid=0.

Reset
REQ-026 While rst=1, outputs SHALL be: state IDLE, out_valid=0, busy=0, result=0, counter=0, internal datapath registers=0.
REQ-027 After rst deasserts, in_ready SHALL equal !flush.
REQ-028 rst asserted mid-operation SHALL abandon the operation immediately, with no result produced.

Verification (XLEN=32)
REQ-029 MUL op_a=7, op_b=0xFFFFFFFD, accept in cycle 0 → out_valid in cycle 33, result=0xFFFFFFEB.
REQ-030 MULH 0x80000000×0x80000000 → result=0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9/2 → result=0xFFFFFFFD; REM of the same operands → result=0xFFFFFFFF; both at cycle 33.
REQ-032 DIVU 5/0 → result=0xFFFFFFFF in cycle 1.
- REMU 5/0 → result=5 in cycle 1.
- DIV 0x80000000/0xFFFFFFFF → result=0x80000000 in cycle 1.
- REM of the same operands → result=0 in cycle 1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stay stable.
- in_ready stays 0 throughout.
- With out_ready=1, the state is IDLE next cycle.
REQ-034 Abort cases:
- flush in CALC cycle 10 → IDLE next cycle; out_valid never asserts.
- rst in CALC → all outputs take reset values immediately.
- A new MUL 3×4 after either abort → result=12.
